// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_pkg : shared width constant, operation encodings and helpers       |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
package alu_pkg;

  localparam int WIDTH = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  // Logic ops live in the upper half of the encoding space.
  function automatic logic is_logic_op(input alu_op_e op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_adder64.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_adder64 : combinational add/subtract with signed overflow detect   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module alu_adder64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  // Subtraction as a + ~b + 1; the carry out of the top bit is dropped.
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

  // Same-signed effective operands producing a differently-signed result.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | alu : one-cycle registered add/sub/and/xor; ALU_CC_EN adds zf/sf/of    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] ans,
`ifdef ALU_CC_EN
  output logic             zf,
  output logic             sf,
  output logic             of,
`endif
  output logic             overflow
);

  alu_op_e          op;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] ans_d, ans_q;
  logic             ovf_d, ovf_q;

  assign op  = alu_op_e'(control);
  assign sub = (op == ALU_SUB);

  alu_adder64 #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (A),
    .b   (B),
    .sub (sub),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_comb begin
    out_valid_d = in_valid;
    s_d         = s_q;
    ans_d       = ans_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      unique case (op)
        ALU_ADD, ALU_SUB: begin
          s_d   = sum;
          ans_d = '0;
          ovf_d = add_ovf;
        end
        ALU_AND: begin
          s_d   = '0;
          ans_d = A & B;
          ovf_d = 1'b0;
        end
        ALU_XOR: begin
          s_d   = '0;
          ans_d = A ^ B;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      ans_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      ans_q       <= ans_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign ans       = ans_q;
  assign overflow  = ovf_q;

`ifdef ALU_CC_EN
  logic             zf_d, zf_q;
  logic             sf_d, sf_q;
  logic             of_d, of_q;
  logic [WIDTH-1:0] sel_result;

  // Flags track the result that the current operation actually produced.
  always_comb begin
    sel_result = is_logic_op(op) ? ans_d : s_d;
    zf_d       = zf_q;
    sf_d       = sf_q;
    of_d       = of_q;
    if (in_valid) begin
      zf_d = (sel_result == '0);
      sf_d = sel_result[WIDTH-1];
      of_d = ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_alu : scoreboard-based self-checking bench for alu                  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_alu;

  typedef struct packed {
    logic [63:0] s;
    logic [63:0] ans;
    logic        ovf;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  control;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic [63:0] S;
  logic [63:0] ans;
  logic        overflow;
`ifdef ALU_CC_EN
  logic        zf, sf, of;
`endif

  exp_t sb[$];
  exp_t last;
  exp_t exp_v;
  int   n_cmp;
  int   n_err;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .control   (control),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .S         (S),
    .ans       (ans),
`ifdef ALU_CC_EN
    .zf        (zf),
    .sf        (sf),
    .of        (of),
`endif
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed overflow from a 65-bit exact result.
  function automatic exp_t model(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic signed [64:0] wide;
    logic [63:0] sel;
    e = '0;
    case (c)
      2'b00: begin
        wide  = $signed({a[63], a}) + $signed({b[63], b});
        e.s   = wide[63:0];
        e.ovf = (wide[64] != wide[63]);
      end
      2'b01: begin
        wide  = $signed({a[63], a}) - $signed({b[63], b});
        e.s   = wide[63:0];
        e.ovf = (wide[64] != wide[63]);
      end
      2'b10: e.ans = a & b;
      default: e.ans = a ^ b;
    endcase
    sel  = c[1] ? e.ans : e.s;
    e.zf = (sel == 64'd0);
    e.sf = sel[63];
    e.of = e.ovf;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [1:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = v;
    control  = c;
    A        = a;
    B        = b;
    if (v) sb.push_back(model(c, a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    control  = 2'b00;
    A        = '0;
    B        = '0;
    #12;
    n_cmp++;
    if ({out_valid, S, ans, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b S=%h ans=%h ovf=%b, want all zero", out_valid, S, ans, overflow);
    end
`ifdef ALU_CC_EN
    n_cmp++;
    if ({zf, sf, of} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b%b%b, want 000", zf, sf, of);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    last  = '0;
  endtask

  task automatic test_directed;
    vec_t vecs[8];
    vecs[0] = '{2'b00, 64'd5, 64'd7};
    vecs[1] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[2] = '{2'b01, 64'd3, 64'd5};
    vecs[3] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1};
    vecs[4] = '{2'b10, 64'hF0F0, 64'hFF00};
    vecs[5] = '{2'b11, 64'hF0F0, 64'hFF00};
    vecs[6] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[7] = '{2'b01, 64'h1234, 64'h1234};
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      exp_v = sb.pop_front();
      last  = exp_v;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_valid: got %b want 1", i, out_valid);
      end
      n_cmp++;
      if (S !== exp_v.s) begin
        n_err++;
        $display("FAIL dir%0d_S: got %h want %h", i, S, exp_v.s);
      end
      n_cmp++;
      if (ans !== exp_v.ans) begin
        n_err++;
        $display("FAIL dir%0d_ans: got %h want %h", i, ans, exp_v.ans);
      end
      n_cmp++;
      if (overflow !== exp_v.ovf) begin
        n_err++;
        $display("FAIL dir%0d_ovf: got %b want %b", i, overflow, exp_v.ovf);
      end
`ifdef ALU_CC_EN
      n_cmp++;
      if ({zf, sf, of} !== {exp_v.zf, exp_v.sf, exp_v.of}) begin
        n_err++;
        $display("FAIL dir%0d_flags: got %b%b%b want %b%b%b", i, zf, sf, of, exp_v.zf, exp_v.sf, exp_v.of);
      end
`endif
    end
    // Fixed anchors independent of the model.
    n_cmp++;
    if (S !== 64'd0) begin
      n_err++;
      $display("FAIL zero_sub_S: got %h want 0", S);
    end
  endtask

  task automatic test_hold;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'(k), 64'hDEAD_BEEF_0000_0001 + 64'(k), 64'h0123_4567_89AB_CDEF);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold%0d_valid: got %b want 0", k, out_valid);
      end
      n_cmp++;
      if ({S, ans, overflow} !== {last.s, last.ans, last.ovf}) begin
        n_err++;
        $display("FAIL hold%0d_data: got S=%h ans=%h ovf=%b want S=%h ans=%h ovf=%b",
                 k, S, ans, overflow, last.s, last.ans, last.ovf);
      end
`ifdef ALU_CC_EN
      n_cmp++;
      if ({zf, sf, of} !== {last.zf, last.sf, last.of}) begin
        n_err++;
        $display("FAIL hold%0d_flags: got %b%b%b want %b%b%b", k, zf, sf, of, last.zf, last.sf, last.of);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    logic [1:0]  c;
    for (int k = 0; k < 24; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (k % 4 == 1) a[63:62] = 2'b01;
      if (k % 4 == 2) b[63:62] = 2'b10;
      c = 2'($urandom_range(0, 3));
      drive(1'b1, c, a, b);
      exp_v = sb.pop_front();
      last  = exp_v;
      n_cmp++;
      if ({out_valid, S, ans, overflow} !== {1'b1, exp_v.s, exp_v.ans, exp_v.ovf}) begin
        n_err++;
        $display("FAIL b2b%0d: got v=%b S=%h ans=%h ovf=%b want v=1 S=%h ans=%h ovf=%b",
                 k, out_valid, S, ans, overflow, exp_v.s, exp_v.ans, exp_v.ovf);
      end
`ifdef ALU_CC_EN
      n_cmp++;
      if ({zf, sf, of} !== {exp_v.zf, exp_v.sf, exp_v.of}) begin
        n_err++;
        $display("FAIL b2b%0d_flags: got %b%b%b want %b%b%b", k, zf, sf, of, exp_v.zf, exp_v.sf, exp_v.of);
      end
`endif
    end
  endtask

  task automatic test_midstream_reset;
    drive(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    void'(sb.pop_front());
    // Leave in_valid high and pull reset between edges.
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if ({out_valid, S, ans, overflow} !== '0) begin
      n_err++;
      $display("FAIL midrst_async: got v=%b S=%h ans=%h ovf=%b want all zero", out_valid, S, ans, overflow);
    end
`ifdef ALU_CC_EN
    n_cmp++;
    if ({zf, sf, of} !== 3'b000) begin
      n_err++;
      $display("FAIL midrst_flags: got %b%b%b want 000", zf, sf, of);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, S, ans, overflow} !== '0) begin
      n_err++;
      $display("FAIL midrst_release: got v=%b S=%h ans=%h ovf=%b want all zero", out_valid, S, ans, overflow);
    end
    // Reset again, then release with a valid operand present at the first edge.
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b11, 64'hAAAA_0000_5555_FFFF, 64'hFFFF_FFFF_0000_0000);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({out_valid, S, ans, overflow} !== {1'b1, 64'd0, 64'h5555_FFFF_5555_FFFF, 1'b0}) begin
      n_err++;
      $display("FAIL rst_release_valid: got v=%b S=%h ans=%h ovf=%b want v=1 S=0 ans=5555ffff5555ffff ovf=0",
               out_valid, S, ans, overflow);
    end
    n_cmp++;
    if (ans !== exp_v.ans) begin
      n_err++;
      $display("FAIL rst_release_model: got %h want %h", ans, exp_v.ans);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last  = '0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
